// File: rtl/cabac_neighbour_buf_1p_if.sv
// Bus bundle for the CABAC neighbour line buffer.
// master: context-selection / neighbour-write side (drives requests).
// slave : the buffer itself (drives read data, handshake and clear status).
// Signals: clr_start/clr_busy/clr_done  clear sequencer control and status
//          r_en/r_addr/r_data/r_valid   read request and registered response
//          w_en/w_addr/w_data/w_rdy     write request, accepted on w_en && w_rdy
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 4
`endif

interface cabac_neighbour_buf_1p_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = `PIC_X_WIDTH
);
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic              r_en;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_rdy;

    modport master (
        output clr_start, r_en, r_addr, w_en, w_addr, w_data,
        input  clr_busy, clr_done, r_data, r_valid, w_rdy
    );

    modport slave (
        input  clr_start, r_en, r_addr, w_en, w_addr, w_data,
        output clr_busy, clr_done, r_data, r_valid, w_rdy
    );
endinterface

// File: rtl/cabac_neighbour_buf_1p.sv
// Single-port neighbour line buffer for the CABAC encoder.
// One DATA_W-bit context word per horizontal position. Reads own the RAM port;
// writes that lose arbitration park in a one-entry pending buffer and drain on
// the next cycle without a read. A clear sequencer writes INIT_VAL to every
// entry, one per cycle, after a clr_start pulse.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   bus (slave)   read/write/clear handshake bundle
//   dbg_clear     1 while the FSM is in CLEAR
//   dbg_pend_vld  1 while the pending write buffer holds an entry
// Handshake: a read is accepted on every cycle r_en is high outside CLEAR and
// answers with a one-cycle r_valid pulse the next cycle; a write is accepted
// exactly when w_en && w_rdy (out-of-range writes are accepted and dropped).
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 4
`endif

module cabac_neighbour_buf_1p #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = `PIC_X_WIDTH,
    parameter int                DEPTH    = 1 << ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cabac_neighbour_buf_1p_if.slave bus,
    output logic                    dbg_clear,
    output logic                    dbg_pend_vld
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              pend_vld;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;

    logic              idle, w_in_range, r_in_range;
    logic              w_take, rd_take, drain, direct, pend_load, clr_last;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] rd_src;

    assign idle       = (state == IDLE);
    assign w_in_range = ({1'b0, bus.w_addr} < DEPTH_EXT);
    assign r_in_range = ({1'b0, bus.r_addr} < DEPTH_EXT);

    assign bus.clr_busy = ~idle;
    assign bus.w_rdy    = idle & ~(pend_vld & bus.r_en);
    assign dbg_clear    = ~idle;
    assign dbg_pend_vld = pend_vld;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        bus.clr_done = 1'b0;
        ram_we       = 1'b0;
        ram_waddr    = bus.w_addr;
        ram_wdata    = bus.w_data;
        rd_src       = INIT_VAL;

        // Port arbitration: read, then pending drain, then direct write.
        w_take    = bus.w_en & bus.w_rdy & w_in_range;
        rd_take   = idle & bus.r_en;
        drain     = idle & ~bus.r_en & pend_vld;
        direct    = idle & ~bus.r_en & ~pend_vld & w_take;
        // Port busy this cycle: park the write (replacing a draining entry).
        pend_load = w_take & (bus.r_en | pend_vld);
        clr_last  = ~idle & (cnt == LAST);

        if (bus.clr_start) begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
        end else if (clr_last) begin
            state_nxt    = IDLE;
            cnt_nxt      = '0;
            bus.clr_done = 1'b1;
        end else if (!idle) begin
            cnt_nxt = cnt + ADDR_W'(1);
        end

        if (!idle) begin
            ram_we    = 1'b1;
            ram_waddr = cnt;
            ram_wdata = INIT_VAL;
        end else if (drain) begin
            ram_we    = 1'b1;
            ram_waddr = pend_addr;
            ram_wdata = pend_data;
        end else if (direct) begin
            ram_we = 1'b1;
        end

        // Newest copy wins: same-cycle write, then pending entry, then array.
        if (!r_in_range)
            rd_src = INIT_VAL;
        else if (w_take && (bus.w_addr == bus.r_addr))
            rd_src = bus.w_data;
        else if (pend_vld && (pend_addr == bus.r_addr))
            rd_src = pend_data;
        else
            rd_src = mem[bus.r_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr_start) begin
            pend_vld <= 1'b0;
        end else if (pend_load) begin
            pend_vld  <= 1'b1;
            pend_addr <= bus.w_addr;
            pend_data <= bus.w_data;
        end else if (drain) begin
            pend_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.r_data  <= '0;
            bus.r_valid <= 1'b0;
        end else begin
            bus.r_valid <= rd_take;
            if (rd_take)
                bus.r_data <= rd_src;
        end
    end

    // Array contents survive reset, but no write lands on a reset edge.
    always_ff @(posedge clk) begin
        if (rst_n && ram_we)
            mem[ram_waddr] <= ram_wdata;
    end
endmodule

// File: tb/tb_cabac_neighbour_buf_1p.sv
// Self-checking bench for cabac_neighbour_buf_1p.
// dut_a: DEPTH=16, INIT_VAL=0xFF; dut_b: DEPTH=12 with ADDR_W=4, INIT_VAL=0xA5.
// A reference model of visible contents produces expected read data, which is
// queued when a read is issued and compared when r_valid appears.
module tb_cabac_neighbour_buf_1p;
    localparam logic [7:0] INIT_A = 8'hFF;
    localparam logic [7:0] INIT_B = 8'hA5;

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    logic dbg_clear_a, dbg_pend_a, dbg_clear_b, dbg_pend_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_a_q[$];
    logic [7:0] exp_b_q[$];
    logic [7:0] model_a[16];
    logic [7:0] model_b[16];

    cabac_neighbour_buf_1p_if #(.DATA_W(8), .ADDR_W(4)) ifa ();
    cabac_neighbour_buf_1p_if #(.DATA_W(8), .ADDR_W(4)) ifb ();

    cabac_neighbour_buf_1p #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .INIT_VAL(INIT_A)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .bus(ifa), .dbg_clear(dbg_clear_a), .dbg_pend_vld(dbg_pend_a)
    );
    cabac_neighbour_buf_1p #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .INIT_VAL(INIT_B)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .bus(ifb), .dbg_clear(dbg_clear_b), .dbg_pend_vld(dbg_pend_b)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboards ----------------
    always @(posedge clk) begin
        logic [7:0] e;
        #1;
        if (ifa.r_valid === 1'b1) begin
            n_checks++;
            if (exp_a_q.size() == 0)
                $display("FAIL sb_a: r_valid with no read outstanding, r_data=%h", ifa.r_data);
            else begin
                e = exp_a_q.pop_front();
                if (ifa.r_data !== e) $display("FAIL sb_a: r_data=%h expected=%h", ifa.r_data, e);
                else n_pass++;
            end
        end
    end

    always @(posedge clk) begin
        logic [7:0] e;
        #1;
        if (ifb.r_valid === 1'b1) begin
            n_checks++;
            if (exp_b_q.size() == 0)
                $display("FAIL sb_b: r_valid with no read outstanding, r_data=%h", ifb.r_data);
            else begin
                e = exp_b_q.pop_front();
                if (ifb.r_data !== e) $display("FAIL sb_b: r_data=%h expected=%h", ifb.r_data, e);
                else n_pass++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        ifa.clr_start = 0; ifa.r_en = 0; ifa.r_addr = 0; ifa.w_en = 0; ifa.w_addr = 0; ifa.w_data = 0;
        ifb.clr_start = 0; ifb.r_en = 0; ifb.r_addr = 0; ifb.w_en = 0; ifb.w_addr = 0; ifb.w_data = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle on dut_a (b=0) or dut_b (b=1). Acceptance is the observed
    // w_en && w_rdy; the model is updated before the read so write-through holds.
    task automatic cyc(input bit b, input logic re, input logic [3:0] ra,
                       input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       output logic acc);
        if (!b) begin
            ifa.r_en = re; ifa.r_addr = ra; ifa.w_en = we; ifa.w_addr = wa; ifa.w_data = wd;
        end else begin
            ifb.r_en = re; ifb.r_addr = ra; ifb.w_en = we; ifb.w_addr = wa; ifb.w_data = wd;
        end
        #1;
        acc = we && (b ? ifb.w_rdy : ifa.w_rdy);
        if (!b) begin
            if (acc) model_a[wa] = wd;
            if (re) exp_a_q.push_back(model_a[ra]);
        end else begin
            if (acc && wa < 12) model_b[wa] = wd;
            if (re) exp_b_q.push_back(ra < 12 ? model_b[ra] : INIT_B);
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst_a_n = 0; rst_b_n = 0;
        repeat (3) step();
        rst_a_n = 1; rst_b_n = 1;
        step();
        n_checks++; if (ifa.r_data !== 8'h00) $display("FAIL reset_r_data: got %h want 00", ifa.r_data); else n_pass++;
        n_checks++; if (ifa.r_valid !== 1'b0) $display("FAIL reset_r_valid: got %b want 0", ifa.r_valid); else n_pass++;
        n_checks++; if (ifa.clr_busy !== 1'b0) $display("FAIL reset_clr_busy: got %b want 0", ifa.clr_busy); else n_pass++;
        n_checks++; if (ifa.clr_done !== 1'b0) $display("FAIL reset_clr_done: got %b want 0", ifa.clr_done); else n_pass++;
        n_checks++; if (ifa.w_rdy !== 1'b1) $display("FAIL reset_w_rdy: got %b want 1", ifa.w_rdy); else n_pass++;
        n_checks++; if (ifb.w_rdy !== 1'b1) $display("FAIL reset_w_rdy_b: got %b want 1", ifb.w_rdy); else n_pass++;
    endtask

    task automatic test_clear();
        ifa.clr_start = 1;
        step();
        ifa.clr_start = 0;
        for (int k = 0; k < 16; k++) begin
            n_checks++; if (ifa.clr_busy !== 1'b1) $display("FAIL clr_busy[%0d]: got %b want 1", k, ifa.clr_busy); else n_pass++;
            n_checks++; if (ifa.clr_done !== (k == 15)) $display("FAIL clr_done[%0d]: got %b want %b", k, ifa.clr_done, (k == 15)); else n_pass++;
            ifa.r_en = 1; ifa.r_addr = 4'(k); ifa.w_en = 1; ifa.w_addr = 4'(k); ifa.w_data = 8'h00;
            #1;
            n_checks++; if (ifa.w_rdy !== 1'b0) $display("FAIL clr_w_rdy[%0d]: got %b want 0", k, ifa.w_rdy); else n_pass++;
            @(posedge clk); #1;
        end
        idle_inputs();
        n_checks++; if (ifa.clr_busy !== 1'b0) $display("FAIL clr_end_busy: got %b want 0", ifa.clr_busy); else n_pass++;
        n_checks++; if (ifa.clr_done !== 1'b0) $display("FAIL clr_end_done: got %b want 0", ifa.clr_done); else n_pass++;
        for (int i = 0; i < 16; i++) model_a[i] = INIT_A;
        for (int i = 0; i < 16; i++) begin
            logic acc;
            cyc(0, 1, 4'(i), 0, 0, 0, acc);
        end
    endtask

    task automatic test_write_read();
        logic acc;
        cyc(0, 0, 0, 1, 4'd3, 8'h5A, acc);
        n_checks++; if (acc !== 1'b1) $display("FAIL wr_accept: got %b want 1", acc); else n_pass++;
        cyc(0, 1, 4'd3, 0, 0, 0, acc);
        n_checks++; if (ifa.r_valid !== 1'b1) $display("FAIL wr_rd_valid: got %b want 1", ifa.r_valid); else n_pass++;
        n_checks++; if (ifa.r_data !== 8'h5A) $display("FAIL wr_rd_data: got %h want 5a", ifa.r_data); else n_pass++;
        step();
        n_checks++; if (ifa.r_valid !== 1'b0) $display("FAIL rd_pulse: got %b want 0", ifa.r_valid); else n_pass++;
        n_checks++; if (ifa.r_data !== 8'h5A) $display("FAIL rd_hold: got %h want 5a", ifa.r_data); else n_pass++;
    endtask

    task automatic test_write_through();
        logic acc;
        cyc(0, 1, 4'd7, 1, 4'd7, 8'h33, acc);
        n_checks++; if (acc !== 1'b1) $display("FAIL wt_w_rdy: got %b want 1", acc); else n_pass++;
        n_checks++; if (dbg_pend_a !== 1'b1) $display("FAIL wt_pend_set: got %b want 1", dbg_pend_a); else n_pass++;
        n_checks++; if (ifa.r_data !== 8'h33) $display("FAIL wt_r_data: got %h want 33", ifa.r_data); else n_pass++;
        step();
        n_checks++; if (dbg_pend_a !== 1'b0) $display("FAIL wt_pend_drain: got %b want 0", dbg_pend_a); else n_pass++;
        cyc(0, 1, 4'd7, 0, 0, 0, acc);
    endtask

    task automatic test_pending_burst();
        logic acc;
        cyc(0, 1, 4'd0, 1, 4'd2, 8'h21, acc);
        n_checks++; if (acc !== 1'b1) $display("FAIL pb_first_accept: got %b want 1", acc); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 4'(k + 4), 1, 4'd9, 8'h92, acc);
            n_checks++; if (acc !== 1'b0) $display("FAIL pb_w_rdy[%0d]: got %b want 0", k, acc); else n_pass++;
        end
        cyc(0, 0, 0, 1, 4'd9, 8'h92, acc);
        n_checks++; if (acc !== 1'b1) $display("FAIL pb_second_accept: got %b want 1", acc); else n_pass++;
        cyc(0, 1, 4'd9, 0, 0, 0, acc);
        cyc(0, 1, 4'd2, 0, 0, 0, acc);
        step();
        cyc(0, 1, 4'd9, 0, 0, 0, acc);
    endtask

    task automatic test_random();
        logic acc;
        for (int n = 0; n < 300; n++) begin
            cyc(0, ($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), acc);
        end
        step();
    endtask

    task automatic test_clear_reset();
        logic acc;
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 4'(i), 8'(8'h10 + i), acc);
        ifa.clr_start = 1;
        step();
        ifa.clr_start = 0;
        repeat (5) step();
        rst_a_n = 0;
        ifa.r_en = 1; ifa.r_addr = 4'd1;
        step();
        idle_inputs();
        rst_a_n = 1;
        n_checks++; if (ifa.clr_busy !== 1'b0) $display("FAIL cr_busy: got %b want 0", ifa.clr_busy); else n_pass++;
        n_checks++; if (ifa.r_valid !== 1'b0) $display("FAIL cr_r_valid: got %b want 0", ifa.r_valid); else n_pass++;
        n_checks++; if (ifa.clr_done !== 1'b0) $display("FAIL cr_done: got %b want 0", ifa.clr_done); else n_pass++;
        step();
        for (int i = 0; i < 5; i++) model_a[i] = INIT_A;
        for (int i = 0; i < 16; i++) cyc(0, 1, 4'(i), 0, 0, 0, acc);
    endtask

    task automatic test_out_of_range();
        logic acc;
        int   done_at;
        done_at = -1;
        ifb.clr_start = 1;
        step();
        ifb.clr_start = 0;
        for (int k = 0; k < 40 && done_at < 0; k++) begin
            if (ifb.clr_done === 1'b1) done_at = k;
            step();
        end
        n_checks++; if (done_at != 11) $display("FAIL oor_clr_done_cycle: got %0d want 11", done_at); else n_pass++;
        n_checks++; if (ifb.clr_busy !== 1'b0) $display("FAIL oor_clr_busy: got %b want 0", ifb.clr_busy); else n_pass++;
        for (int i = 0; i < 16; i++) model_b[i] = INIT_B;
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 1, 4'(i), 8'(8'h40 + i), acc);
        cyc(1, 1, 4'd1, 1, 4'd13, 8'h77, acc);
        n_checks++; if (dbg_pend_b !== 1'b0) $display("FAIL oor_no_pend: got %b want 0", dbg_pend_b); else n_pass++;
        cyc(1, 1, 4'd13, 0, 0, 0, acc);
        n_checks++; if (ifb.r_data !== INIT_B) $display("FAIL oor_rd13: got %h want %h", ifb.r_data, INIT_B); else n_pass++;
        cyc(1, 1, 4'd14, 1, 4'd14, 8'h66, acc);
        for (int i = 0; i < 12; i++) cyc(1, 1, 4'(i), 0, 0, 0, acc);
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        idle_inputs();
        test_reset();
        test_clear();
        test_write_read();
        test_write_through();
        test_pending_burst();
        test_random();
        test_clear_reset();
        test_out_of_range();
        repeat (3) step();
        n_checks++; if (exp_a_q.size() != 0) $display("FAIL sb_a_drain: %0d reads unanswered, want 0", exp_a_q.size()); else n_pass++;
        n_checks++; if (exp_b_q.size() != 0) $display("FAIL sb_b_drain: %0d reads unanswered, want 0", exp_b_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
